// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and spi_master word widths
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
    localparam int SPI_TX_W = 12;
    localparam int SPI_RX_W = 8;
endpackage

// File: rtl/spi_master_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from ptr with wrap-around
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);
    // walk offsets high to low so the nearest requester at or above ptr wins last
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) win_idx = IW'((int'(ptr) + k) % NREQ);
    end
    assign any = |req;
    assign win = any ? NREQ'(1) << win_idx : '0;
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one spi_master among NREQ requesters
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int TX_W          = SPI_TX_W,
    parameter int RX_W          = SPI_RX_W,
    parameter int START_TIMEOUT = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*TX_W-1:0] req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [RX_W-1:0]      rsp_data,
    output logic                 spi_start,
    output logic [TX_W-1:0]      spi_tx_data,
    input  logic                 spi_busy,
    input  logic [RX_W-1:0]      spi_rx_data,
    input  logic                 spi_rx_rdy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx, widx, widx_nx, pick_idx;
    logic [NREQ-1:0] pick_win, gnt_nx, done_nx;
    logic            pick_any, err_nx, start_nx, got_rx, got_nx, rx_prev, rx_edge;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [RX_W-1:0] rx_cap, cap_nx, rsp_nx;
    logic [TX_W-1:0] tx_nx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign rx_edge = spi_rx_rdy & ~rx_prev;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        widx_nx  = widx;
        gnt_nx   = gnt;
        done_nx  = '0;
        err_nx   = err;
        rsp_nx   = rsp_data;
        start_nx = spi_start;
        tx_nx    = spi_tx_data;
        cnt_nx   = cnt;
        got_nx   = got_rx;
        cap_nx   = rx_cap;
        case (state)
            IDLE: if (pick_any) begin
                state_nx = LAUNCH;
                gnt_nx   = pick_win;
                widx_nx  = pick_idx;
                tx_nx    = req_data[pick_idx*TX_W +: TX_W];
                start_nx = 1'b1;
                cnt_nx   = '0;
                got_nx   = 1'b0;
            end
            LAUNCH: begin
                cnt_nx = (cnt == CW'(START_TIMEOUT)) ? cnt : cnt + CW'(1);
                if (spi_busy) begin
                    state_nx = RUN;
                    start_nx = 1'b0;
                end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
                    state_nx = DONE;
                    start_nx = 1'b0;
                    done_nx  = gnt;
                    err_nx   = 1'b1;
                    rsp_nx   = '0;
                end
            end
            RUN: begin
                got_nx = got_rx | rx_edge;
                cap_nx = rx_edge ? spi_rx_data : rx_cap;
                // an edge in the same cycle busy falls still counts
                if (!spi_busy) begin
                    state_nx = DONE;
                    done_nx  = gnt;
                    err_nx   = !got_nx;
                    rsp_nx   = got_nx ? cap_nx : '0;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                ptr_nx   = (widx == IW'(NREQ - 1)) ? '0 : widx + IW'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            widx        <= '0;
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            rsp_data    <= '0;
            spi_start   <= 1'b0;
            spi_tx_data <= '0;
            cnt         <= '0;
            got_rx      <= 1'b0;
            rx_cap      <= '0;
            rx_prev     <= 1'b1;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            widx        <= widx_nx;
            gnt         <= gnt_nx;
            done        <= done_nx;
            err         <= err_nx;
            rsp_data    <= rsp_nx;
            spi_start   <= start_nx;
            spi_tx_data <= tx_nx;
            cnt         <= cnt_nx;
            got_rx      <= got_nx;
            rx_cap      <= cap_nx;
            rx_prev     <= spi_rx_rdy;
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: scoreboard bench with a behavioural slave and round-robin reference model
module tb_spi_master_arbiter;
    localparam int NREQ = 4;
    localparam int TX_W = 12;
    localparam int RX_W = 8;
    localparam int TMO  = 16;

    logic                 clk, rst;
    logic [NREQ-1:0]      req, gnt, done;
    logic [NREQ*TX_W-1:0] req_data;
    logic                 err, spi_start, spi_busy, spi_rx_rdy;
    logic [RX_W-1:0]      rsp_data, spi_rx_data;
    logic [TX_W-1:0]      spi_tx_data;

    typedef struct { int idx; logic e; logic [RX_W-1:0] rsp; logic [TX_W-1:0] tx; } exp_t;
    typedef struct { int mode; logic [RX_W-1:0] rx; } slv_t;

    exp_t           exp_q[$];
    slv_t           slv_q[$];
    int             checks = 0;
    int             errors = 0;
    int             mptr;
    int             b_cnt[4];
    logic [TX_W-1:0] b_dat[4];

    spi_master_arbiter #(.NREQ(NREQ), .TX_W(TX_W), .RX_W(RX_W), .START_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rsp_data    (rsp_data),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_busy    (spi_busy),
        .spi_rx_data (spi_rx_data),
        .spi_rx_rdy  (spi_rx_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    // first requester with work left, searching upward from p
    function automatic int pick(input int p, input int c[4]);
        for (int k = 0; k < 4; k++) if (c[(p + k) % 4] > 0) return (p + k) % 4;
        return -1;
    endfunction

    // mode: 0 normal, 1 never busy, 2 no rx edge (stale high), 3 rx edge with busy fall, -1 random
    task automatic run_batch(input int mode, input bit fixed, input logic [RX_W-1:0] rxv);
        int c[4];
        int left[4];
        int n, first, w, m, budget;
        exp_t e;
        slv_t s;
        c = b_cnt;
        left = b_cnt;
        n = 0;
        first = -1;
        while (c[0] + c[1] + c[2] + c[3] > 0) begin
            w = pick(mptr, c);
            if (first < 0) first = w;
            c[w]--;
            if (mode >= 0) m = mode;
            else case ($urandom_range(0, 7))
                0:       m = 1;
                1, 2:    m = 2;
                3, 4:    m = 3;
                default: m = 0;
            endcase
            s.mode = m;
            s.rx   = fixed ? rxv : RX_W'($urandom);
            slv_q.push_back(s);
            e.idx = w;
            e.e   = (m == 1 || m == 2);
            e.rsp = e.e ? '0 : s.rx;
            e.tx  = b_dat[w];
            exp_q.push_back(e);
            mptr = (w + 1) % 4;
            n++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_data[i*TX_W +: TX_W] = b_dat[i];
            req[i] = left[i] > 0;
        end
        @(negedge clk);
        check("req_to_gnt", 64'({gnt, spi_start}), 64'({4'(1 << first), 1'b1}));
        budget = n * 80;
        while (left[0] + left[1] + left[2] + left[3] > 0 && budget > 0) begin
            for (int i = 0; i < 4; i++)
                if (done[i] === 1'b1) begin
                    left[i]--;
                    if (left[i] == 0) req[i] = 1'b0;
                end
            @(negedge clk);
            budget--;
        end
        check("batch_complete", 64'(budget > 0), 64'(1));
        req = '0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        slv_q.delete();
    endtask

    // monitor: pops the scoreboard on every done pulse, then checks the one-cycle gnt gap
    initial begin
        exp_t e;
        int pend, nxt;
        pend = 0;
        nxt  = 0;
        forever begin
            @(negedge clk);
            if (rst) pend = 0;
            else begin
                if (pend == 2) begin
                    check("gap_low", 64'(gnt), 64'(0));
                    pend = 1;
                end else if (pend == 1) begin
                    check("regrant", 64'(gnt), 64'(1) << nxt);
                    pend = 0;
                end
                if (done !== '0) begin
                    if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'(0));
                    else begin
                        e = exp_q.pop_front();
                        check("done_pulse", 64'({done, gnt}), 64'({4'(1 << e.idx), 4'(1 << e.idx)}));
                        check("result", 64'({err, rsp_data, spi_tx_data}), 64'({e.e, e.rsp, e.tx}));
                        if (exp_q.size() > 0) begin
                            pend = 2;
                            nxt  = exp_q[0].idx;
                        end
                    end
                end
            end
        end
    end

    // behavioural spi_master: acts out one queued behaviour per observed launch
    initial begin
        slv_t s;
        int n;
        spi_busy    = 1'b0;
        spi_rx_rdy  = 1'b0;
        spi_rx_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && spi_start) begin
                if (slv_q.size() == 0) begin
                    check("unexpected_start", 64'(spi_start), 64'(0));
                    n = 0;
                    while (spi_start && n < 100) begin n++; @(negedge clk); end
                end else begin
                    s = slv_q.pop_front();
                    if (s.mode == 1) begin
                        n = 0;
                        while (spi_start && n < 100) begin n++; @(negedge clk); end
                        check("start_len", 64'(n), 64'(TMO));
                    end else begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        if (s.mode == 2) begin
                            spi_rx_rdy = 1'b1;
                            @(negedge clk);
                        end
                        spi_busy = 1'b1;
                        @(negedge clk);
                        check("start_drop", 64'(spi_start), 64'(0));
                        if (s.mode == 4) begin
                            for (int k = 0; k < 200; k++) begin
                                @(posedge clk);
                                if (rst) break;
                            end
                            @(negedge clk);
                        end else begin
                            repeat ($urandom_range(0, 3)) @(negedge clk);
                            if (s.mode != 2) begin
                                spi_rx_data = s.rx;
                                spi_rx_rdy  = 1'b1;
                            end
                            if (s.mode == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                        end
                        spi_busy = 1'b0;
                        @(negedge clk);
                        spi_rx_rdy  = 1'b0;
                        spi_rx_data = RX_W'($urandom);
                    end
                end
            end
        end
    end

    initial begin
        slv_t s;
        int n;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        mptr = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({gnt, done, err, rsp_data, spi_start, spi_tx_data}), 64'(0));
        rst = 1'b0;
        b_cnt = '{2, 1, 1, 1};
        b_dat = '{12'h111, 12'h222, 12'h333, 12'h444};
        run_batch(0, 1'b0, '0);
        b_cnt = '{0, 0, 1, 0};
        b_dat[2] = 12'hb55;
        run_batch(0, 1'b1, 8'h3c);
        b_cnt = '{1, 1, 0, 0};
        run_batch(0, 1'b0, '0);
        b_cnt = '{0, 1, 0, 0};
        run_batch(1, 1'b0, '0);
        b_cnt = '{0, 0, 0, 1};
        run_batch(2, 1'b0, '0);
        repeat (40) begin
            for (int i = 0; i < 4; i++) begin
                b_cnt[i] = $urandom_range(0, 2);
                b_dat[i] = TX_W'($urandom);
            end
            if (b_cnt[0] + b_cnt[1] + b_cnt[2] + b_cnt[3] == 0) b_cnt[$urandom_range(0, 3)] = 1;
            run_batch(-1, 1'b0, '0);
        end
        b_cnt = '{0, 0, 1, 0};
        run_batch(3, 1'b0, '0);
        // leave ptr at 3, hang a transfer in RUN, then reset it away
        s.mode = 4;
        s.rx   = '0;
        slv_q.push_back(s);
        @(negedge clk);
        req_data[2*TX_W +: TX_W] = TX_W'($urandom);
        req = 4'b0100;
        n = 0;
        while (!(gnt[2] === 1'b1 && spi_start === 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_run", 64'(n < 50), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        check("reset_mid_run", 64'({gnt, done, err, rsp_data, spi_start, spi_tx_data}), 64'(0));
        slv_q.delete();
        mptr = 0;
        b_cnt = '{0, 0, 1, 1};
        b_dat = '{12'h0a5, 12'h15a, 12'h2c3, 12'h3e7};
        run_batch(0, 1'b0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog expired");
    end
endmodule
